aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
Sequencing controller for the AES-128 encryption datapath, sitting between the ATD input block, the round datapath and the I2C output FIFO.
- Accepts a plaintext block when both a key and data are available.
- Steps the round datapath one round per cycle and drives the key-expansion enable.
- Hands the ciphertext to the I2C write path only when its FIFO has room.
- Processes one block at a time; there is no overlap between blocks.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; legal values 10/12/14; only 10 is used in this design.
RND_W, $clog2(NUM_ROUNDS+1), localparam, width of round_num (4 at default).

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
data_ready  input  1  ATD block has a 128-bit plaintext valid; level, held until data_taken
key_received  input  1  I2C block has a valid key loaded; level
fifo_full  input  1  I2C output FIFO cannot accept a block
data_taken  output  1  one-cycle pulse: plaintext consumed; ATD may drop data_ready
load_state  output  1  datapath captures plaintext XOR round key 0
round_en  output  1  datapath executes one round this cycle
key_exp_en  output  1  key schedule advances to the next round key
final_round  output  1  current round omits MixColumns
round_num  output  RND_W  round index being executed; 0 during load
data_out_load  output  1  one-cycle pulse: ciphertext written to the I2C FIFO
busy  output  1  high whenever state != IDLE

Behaviour:
Reset (async, n_rst=0): state=IDLE; every output is 0, including round_num.

States: IDLE, LOAD, ROUND, FINAL, HOLD.
- IDLE:
  - data_ready && key_received -> LOAD.
  - Otherwise stay. data_ready without a key is left pending and is never dropped.
- LOAD (1 cycle):
  - load_state=1, data_taken=1, round_num=0 -> ROUND.
- ROUND:
  - round_en=1, key_exp_en=1, final_round=0.
  - round_num runs 1..NUM_ROUNDS-1, incrementing each cycle.
  - When round_num==NUM_ROUNDS-1 -> FINAL.
- FINAL (1 cycle):
  - round_en=1, key_exp_en=1, final_round=1, round_num=NUM_ROUNDS -> HOLD.
- HOLD:
  - round_en=0; round_num holds NUM_ROUNDS.
  - !fifo_full: data_out_load=1 for exactly one cycle -> IDLE, round_num returns to 0.
  - fifo_full: stay with no pulse. The ciphertext stays valid in the datapath, which does not advance.

Latency: with data_ready and key_received sampled high in cycle 0:
- data_taken in cycle 1.
- Rounds in cycles 2..NUM_ROUNDS+1.
- data_out_load no earlier than cycle NUM_ROUNDS+2 (12 at default).
- Minimum block-to-block spacing is NUM_ROUNDS+3 cycles.

Boundary conditions:
- key_received falling mid-block is ignored; the block completes with the key already loaded. It is re-checked only in IDLE.
- data_ready asserting during LOAD..HOLD is not taken until IDLE is re-entered.
- fifo_full toggling in HOLD: the pulse fires on the first cycle fifo_full=0.
- Reset in any state aborts the block immediately. No data_out_load is issued, and the ATD block keeps the block if data_taken had not yet pulsed.
- All outputs are registered or decoded from the registered state only; there is no combinational path from inputs to outputs.

Optional Feature:
AES_CTRL_PERF_EN:
- Defined: adds output blk_count [15:0], reset 0. It increments on each data_out_load pulse and wraps 0xFFFF->0x0000. A second output hold_cycles [15:0], reset 0, counts cycles spent in HOLD with fifo_full=1 and saturates at 0xFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package aes_ctrl_pkg holds:
  - the typedef enum logic [2:0] ctrl_state_t {IDLE, LOAD, ROUND, FINAL, HOLD};
  - localparams AES128_ROUNDS=10, AES192_ROUNDS=12, AES256_ROUNDS=14.
- One sub-module is natural: aes_round_counter, a RND_W-bit counter with clear, enable and rollover-compare against NUM_ROUNDS-1, producing round_num and the last-round flag.
- FSM and output decode stay in aes_round_ctrl.

Test Plan:
1. Reset mid-ROUND at round_num=5 -> all outputs 0 immediately; state IDLE; no data_out_load ever pulses.
2. key_received=1, data_ready=1 at cycle 0, fifo_full=0:
   - data_taken@1.
   - round_num 1..9 @2..10, final_round=1 with round_num=10 @11.
   - data_out_load@12, busy low @13.
3. data_ready=1, key_received=0 for 20 cycles -> no data_taken, busy=0. Raise key -> LOAD the next cycle.
4. fifo_full=1 on entering HOLD for 7 cycles -> round_num holds 10, no pulse; data_out_load in the first cycle after fifo_full falls, exactly one pulse.
5. data_ready held high continuously with key present -> data_taken pulses every 13 cycles; data_out_load count equals data_taken count.
6. AES_CTRL_PERF_EN defined -> after 3 blocks, blk_count=3; hold_cycles equals the number of cycles fifo_full was held in HOLD (7 from scenario 4).

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and round-count constants for the AES round controller.
package aes_ctrl_pkg;
  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, HOLD} ctrl_state_t;
endpackage

// File: rtl/aes_round_counter.sv
// Round index counter: clear, increment, and a flag for the last non-final round.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int RND_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [RND_W-1:0] o_cnt,
  output logic             o_last
);
  logic [RND_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + RND_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == RND_W'(NUM_ROUNDS - 1));
endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 sequencing FSM: LOAD, one round per cycle, then HOLD until the output FIFO has room.
// Optional AES_CTRL_PERF_EN adds blk_count and hold_cycles performance counters.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter  int NUM_ROUNDS = AES128_ROUNDS,
  localparam int RND_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             data_ready,
  input  logic             key_received,
  input  logic             fifo_full,
  output logic             data_taken,
  output logic             load_state,
  output logic             round_en,
  output logic             key_exp_en,
  output logic             final_round,
  output logic [RND_W-1:0] round_num,
  output logic             data_out_load,
  output logic             busy
`ifdef AES_CTRL_PERF_EN
  ,
  output logic [15:0]      blk_count,
  output logic [15:0]      hold_cycles
`endif
);
  ctrl_state_t r_state;
  ctrl_state_t w_next;
  logic        r_dol;
  logic        w_last;
  logic        w_cnt_clr;
  logic        w_cnt_en;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The write pulse is registered from fifo_full so no input reaches an output
  // combinationally; it therefore appears the cycle after room is seen.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dol <= 1'b0;
    end else begin
      r_dol <= ((r_state == FINAL) || ((r_state == HOLD) && !r_dol)) && !fifo_full;
    end
  end

  always_comb begin
    w_next      = r_state;
    data_taken  = 1'b0;
    load_state  = 1'b0;
    round_en    = 1'b0;
    key_exp_en  = 1'b0;
    final_round = 1'b0;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (data_ready && key_received) w_next = LOAD;
      end
      LOAD: begin
        load_state = 1'b1;
        data_taken = 1'b1;
        w_cnt_en   = 1'b1;
        w_next     = ROUND;
      end
      ROUND: begin
        round_en   = 1'b1;
        key_exp_en = 1'b1;
        w_cnt_en   = 1'b1;
        if (w_last) w_next = FINAL;
      end
      FINAL: begin
        round_en    = 1'b1;
        key_exp_en  = 1'b1;
        final_round = 1'b1;
        w_next      = HOLD;
      end
      HOLD: begin
        if (r_dol) begin
          w_cnt_clr = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign data_out_load = r_dol;
  assign busy          = (r_state != IDLE);

  aes_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RND_W      (RND_W)
  ) u_rnd_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_cnt  (round_num),
    .o_last (w_last)
  );

`ifdef AES_CTRL_PERF_EN
  logic [15:0] r_blk_count;
  logic [15:0] r_hold_cycles;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_blk_count   <= '0;
      r_hold_cycles <= '0;
    end else begin
      if (r_dol) r_blk_count <= r_blk_count + 16'd1;
      if ((r_state == HOLD) && fifo_full && (r_hold_cycles != 16'hFFFF))
        r_hold_cycles <= r_hold_cycles + 16'd1;
    end
  end

  assign blk_count   = r_blk_count;
  assign hold_cycles = r_hold_cycles;
`endif
endmodule
